// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: synchronises, debounces and classifies BTN_NUM front-panel
// buttons into PRESS / RELEASE / LONG (/ REPEAT) events, queued in a small FIFO
// and presented on a valid/ready stream next to the debounced button levels.
//
// Optional build macro: BTN_EVT_AUTOREPEAT_EN -- when defined, a held button
// emits a REPEAT event every REPEAT_CYCLES after its LONG event. When undefined
// no repeat logic exists and evt_type 3 is never produced.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   btn_in       raw asynchronous button pins
//   btn_state    debounced level per channel, 1 = pressed
//   evt_valid    event head valid
//   evt_ready    consumer accepts head when evt_valid & evt_ready
//   evt_id       channel index of the head event
//   evt_type     0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   evt_overflow sticky, an event was dropped (full FIFO or duplicate pending)
//   ovf_clr      clears evt_overflow (a same-cycle set wins)
module btn_event_ctrl #(
  parameter int BTN_NUM           = 4,
  parameter int ACTIVE_LOW        = 1,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter int FIFO_DEPTH        = 8,
  localparam int ID_W = (BTN_NUM > 1) ? $clog2(BTN_NUM) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [BTN_NUM-1:0] btn_in,
  output logic [BTN_NUM-1:0] btn_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_type,
  output logic               evt_overflow,
  input  logic               ovf_clr
);

  // Elaboration-time parameter sanity
  if (BTN_NUM < 1 || BTN_NUM > 16 || DEBOUNCE_CYCLES < 2 ||
      LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("btn_event_ctrl: illegal parameter combination");
  end

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_RELEASE = 2'd1;
  localparam logic [1:0] T_LONG    = 2'd2;
  localparam logic [1:0] T_REPEAT  = 2'd3;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = ID_W + 2;

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HOLD_MAX = HD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HD_W-1:0] HOLD_SAT = HD_W'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  // Synchronisers reset to the idle pin level so a reset never looks like a
  // press edge on the following cycles.
  localparam logic [BTN_NUM-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {S_RELEASED, S_PRESSED, S_HELD} state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [BTN_NUM-1:0] sync1_q, sync2_q, level;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign level = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce: toggle btn_state after DEBOUNCE_CYCLES consecutive differing samples
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0]    db_cnt_q [BTN_NUM];
  logic [BTN_NUM-1:0] db_toggle, rise, fall;

  always_comb begin
    for (int i = 0; i < BTN_NUM; i++) begin
      db_toggle[i] = (level[i] != btn_state[i]) && (db_cnt_q[i] == DB_MAX);
    end
  end

  // The FSMs react on the same edge btn_state changes, not one cycle later.
  assign rise = db_toggle & ~btn_state;
  assign fall = db_toggle &  btn_state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_state <= '0;
      for (int i = 0; i < BTN_NUM; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_NUM; i++) begin
        if (level[i] == btn_state[i] || db_toggle[i]) begin
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
        if (db_toggle[i]) btn_state[i] <= ~btn_state[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel classification FSM
  // ---------------------------------------------------------------------------
  state_t                  st_q   [BTN_NUM];
  state_t                  st_d   [BTN_NUM];
  logic [HD_W-1:0]         hold_q [BTN_NUM];
  logic [HD_W-1:0]         hold_d [BTN_NUM];
  logic [BTN_NUM-1:0][3:0] set_evt;   // indexed by event type code
`ifdef BTN_EVT_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] REP_MAX = RP_W'(REPEAT_CYCLES - 1);
  logic [RP_W-1:0] rep_q [BTN_NUM];
  logic [RP_W-1:0] rep_d [BTN_NUM];
`endif

  always_comb begin
    for (int i = 0; i < BTN_NUM; i++) begin
      st_d[i]    = st_q[i];
      hold_d[i]  = hold_q[i];
      set_evt[i] = '0;
`ifdef BTN_EVT_AUTOREPEAT_EN
      rep_d[i]   = '0;
`endif
      case (st_q[i])
        S_RELEASED: begin
          hold_d[i] = '0;
          if (rise[i]) begin
            st_d[i]             = S_PRESSED;
            set_evt[i][T_PRESS] = 1'b1;
          end
        end
        S_PRESSED: begin
          if (fall[i]) begin
            st_d[i]               = S_RELEASED;
            hold_d[i]             = '0;
            set_evt[i][T_RELEASE] = 1'b1;
          end else if (hold_q[i] == HOLD_MAX) begin
            st_d[i]            = S_HELD;
            hold_d[i]          = HOLD_SAT;
            set_evt[i][T_LONG] = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        S_HELD: begin
          // hold counter stays saturated at LONG_PRESS_CYCLES here
          if (fall[i]) begin
            st_d[i]               = S_RELEASED;
            hold_d[i]             = '0;
            set_evt[i][T_RELEASE] = 1'b1;
          end
`ifdef BTN_EVT_AUTOREPEAT_EN
          else if (rep_q[i] == REP_MAX) begin
            set_evt[i][T_REPEAT] = 1'b1;
            rep_d[i]             = '0;
          end else begin
            rep_d[i] = rep_q[i] + 1'b1;
          end
`endif
        end
        default: begin
          st_d[i]   = S_RELEASED;
          hold_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < BTN_NUM; i++) begin
        st_q[i]   <= S_RELEASED;
        hold_q[i] <= '0;
`ifdef BTN_EVT_AUTOREPEAT_EN
        rep_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < BTN_NUM; i++) begin
        st_q[i]   <= st_d[i];
        hold_q[i] <= hold_d[i];
`ifdef BTN_EVT_AUTOREPEAT_EN
        rep_q[i]  <= rep_d[i];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags and arbiter: lowest channel first, then PRESS, LONG, REPEAT,
  // RELEASE within a channel. The winner is cleared whether or not it fits.
  // ---------------------------------------------------------------------------
  logic [BTN_NUM-1:0][3:0] pend_q, pend_d, clr_evt;
  logic                    win_vld;
  logic [ID_W-1:0]         win_id;
  logic [1:0]              win_ty;
  logic                    dup;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_ty  = T_PRESS;
    // Descending scan: the last hit is the lowest index.
    for (int i = BTN_NUM - 1; i >= 0; i--) begin
      if (|pend_q[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
        if (pend_q[i][T_PRESS])       win_ty = T_PRESS;
        else if (pend_q[i][T_LONG])   win_ty = T_LONG;
        else if (pend_q[i][T_REPEAT]) win_ty = T_REPEAT;
        else                          win_ty = T_RELEASE;
      end
    end
    for (int i = 0; i < BTN_NUM; i++) begin
      clr_evt[i] = (win_vld && (win_id == ID_W'(i))) ? (4'b0001 << win_ty) : 4'b0000;
    end
    pend_d = (pend_q & ~clr_evt) | set_evt;
    // Re-setting a flag that is still waiting collapses two events into one.
    dup    = |(set_evt & pend_q & ~clr_evt);
  end

  always_ff @(posedge clk) begin
    if (!resetn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // ---------------------------------------------------------------------------
  // Event FIFO with a registered head stage
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, head_idx;
  logic [CW-1:0] count_q, remain;
  logic          pop, push, drop, full;

  assign pop  = evt_valid & evt_ready;
  assign full = (count_q == FULL_CNT);
  assign push = win_vld & (~full | pop);
  assign drop = win_vld & ~push;

  // Entries already stored after this cycle's pop; an entry written on this
  // edge is not yet visible and reaches the head register one edge later.
  assign remain   = count_q - CW'(pop);
  assign head_idx = rd_ptr_q + AW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {win_id, win_ty};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_type     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= remain + CW'(push);
      evt_valid <= (remain != '0);
      if (remain != '0) {evt_id, evt_type} <= mem_q[head_idx];
      evt_overflow <= drop | dup | (evt_overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed checks of btn_event_ctrl with short debounce,
// long-press and repeat periods (4 / 20 / 8 cycles) and a 4-entry FIFO.
// Cycle numbers in the tests count clock edges after the stimulus change.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] btn_in;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Accepted events: cycle at which head was valid & ready, id, type
  int q_t[$];
  int q_id[$];
  int q_ty[$];

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .BTN_NUM(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .btn_state(btn_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
  );

  task automatic clear_log();
    q_t.delete();
    q_id.delete();
    q_ty.delete();
  endtask

  // Advance n edges; a head that is valid & ready before an edge is popped by it.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        q_t.push_back(cyc);
        q_id.push_back(int'(evt_id));
        q_ty.push_back(int'(evt_type));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; btn_in = 4'hF; evt_ready = 1'b0; ovf_clr = 1'b0;
    step(2);
    total++; if (btn_state !== 4'h0) begin bad++; $display("FAIL reset_btn_state: got %b want 0000", btn_state); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    total++; if (evt_id !== 2'd0 || evt_type !== 2'd0) begin bad++; $display("FAIL reset_head: got id=%0d ty=%0d want 0/0", evt_id, evt_type); end
    total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", evt_overflow); end
    resetn = 1'b1;
    step(8);
    total++; if (evt_valid !== 1'b0 || btn_state !== 4'h0) begin bad++; $display("FAIL idle_after_reset: got valid=%b state=%b want 0/0000", evt_valid, btn_state); end
  endtask

  task automatic test_single_press();
    int t0;
    int off[2] = '{8, 18};
    int eid[2] = '{2, 2};
    int ety[2] = '{0, 1};
    clear_log();
    evt_ready = 1'b1;
    t0 = cyc;
    btn_in[2] = 1'b0;
    step(5);
    total++; if (btn_state !== 4'b0000) begin bad++; $display("FAIL press_state_c5: got %b want 0000", btn_state); end
    step(1);
    total++; if (btn_state !== 4'b0100) begin bad++; $display("FAIL press_state_c6: got %b want 0100", btn_state); end
    step(4);
    btn_in[2] = 1'b1;
    step(14);
    total++; if (q_t.size() != 2) begin bad++; $display("FAIL press_event_count: got %0d want 2", q_t.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= q_t.size()) begin
        bad++; $display("FAIL press_event_%0d: missing, want t=%0d id=%0d ty=%0d", i, off[i], eid[i], ety[i]);
      end else if (q_t[i] - t0 != off[i] || q_id[i] != eid[i] || q_ty[i] != ety[i]) begin
        bad++; $display("FAIL press_event_%0d: got t=%0d id=%0d ty=%0d want t=%0d id=%0d ty=%0d",
                        i, q_t[i] - t0, q_id[i], q_ty[i], off[i], eid[i], ety[i]);
      end
    end
    total++; if (btn_state !== 4'b0000) begin bad++; $display("FAIL release_state: got %b want 0000", btn_state); end
  endtask

  task automatic test_glitch();
    logic seen;
    clear_log();
    seen = 1'b0;
    btn_in[0] = 1'b0;
    step(3);
    btn_in[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step(1);
      seen = seen | btn_state[0];
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_state: got 1 want 0"); end
    total++; if (q_t.size() != 0) begin bad++; $display("FAIL glitch_events: got %0d want 0", q_t.size()); end
  endtask

  task automatic test_long_press();
    int t0;
`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int NE = 5;
    int off[NE] = '{8, 28, 36, 44, 48};
    int ety[NE] = '{0, 2, 3, 3, 1};
`else
    localparam int NE = 3;
    int off[NE] = '{8, 28, 48};
    int ety[NE] = '{0, 2, 1};
`endif
    clear_log();
    evt_ready = 1'b1;
    t0 = cyc;
    btn_in[1] = 1'b0;
    step(40);
    btn_in[1] = 1'b1;
    step(16);
    total++; if (q_t.size() != NE) begin bad++; $display("FAIL long_event_count: got %0d want %0d", q_t.size(), NE); end
    for (int i = 0; i < NE; i++) begin
      total++;
      if (i >= q_t.size()) begin
        bad++; $display("FAIL long_event_%0d: missing, want t=%0d id=1 ty=%0d", i, off[i], ety[i]);
      end else if (q_t[i] - t0 != off[i] || q_id[i] != 1 || q_ty[i] != ety[i]) begin
        bad++; $display("FAIL long_event_%0d: got t=%0d id=%0d ty=%0d want t=%0d id=1 ty=%0d",
                        i, q_t[i] - t0, q_id[i], q_ty[i], off[i], ety[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int off[8] = '{8, 9, 10, 11, 20, 21, 22, 23};
    int eid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ety[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    clear_log();
    evt_ready = 1'b1;
    t0 = cyc;
    btn_in = 4'h0;
    step(12);
    btn_in = 4'hF;
    step(14);
    total++; if (q_t.size() != 8) begin bad++; $display("FAIL b2b_event_count: got %0d want 8", q_t.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= q_t.size()) begin
        bad++; $display("FAIL b2b_event_%0d: missing, want t=%0d id=%0d ty=%0d", i, off[i], eid[i], ety[i]);
      end else if (q_t[i] - t0 != off[i] || q_id[i] != eid[i] || q_ty[i] != ety[i]) begin
        bad++; $display("FAIL b2b_event_%0d: got t=%0d id=%0d ty=%0d want t=%0d id=%0d ty=%0d",
                        i, q_t[i] - t0, q_id[i], q_ty[i], off[i], eid[i], ety[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int s;
    int eid[4] = '{0, 1, 2, 0};
    int ety[4] = '{0, 0, 0, 1};
    clear_log();
    evt_ready = 1'b0;
    btn_in = 4'b1000;
    step(10);
    btn_in = 4'hF;
    step(12);
    total++; if (evt_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", evt_overflow); end
    total++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== 2'd0) begin
      bad++; $display("FAIL ovf_head_stable: got v=%b id=%0d ty=%0d want 1/0/0", evt_valid, evt_id, evt_type);
    end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", evt_overflow); end
    s = cyc;
    evt_ready = 1'b1;
    step(6);
    total++; if (q_t.size() != 4) begin bad++; $display("FAIL drain_count: got %0d want 4", q_t.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= q_t.size()) begin
        bad++; $display("FAIL drain_event_%0d: missing, want t=%0d id=%0d ty=%0d", i, i, eid[i], ety[i]);
      end else if (q_t[i] - s != i || q_id[i] != eid[i] || q_ty[i] != ety[i]) begin
        bad++; $display("FAIL drain_event_%0d: got t=%0d id=%0d ty=%0d want t=%0d id=%0d ty=%0d",
                        i, q_t[i] - s, q_id[i], q_ty[i], i, eid[i], ety[i]);
      end
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", evt_valid); end
  endtask

  task automatic test_mid_reset();
    int r;
    clear_log();
    evt_ready = 1'b0;
    btn_in = 4'b1100;
    step(12);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL queued_before_reset: got %b want 1", evt_valid); end
    resetn = 1'b0;
    btn_in[1] = 1'b1;
    step(1);
    total++; if (evt_valid !== 1'b0 || btn_state !== 4'h0) begin
      bad++; $display("FAIL mid_reset: got valid=%b state=%b want 0/0000", evt_valid, btn_state);
    end
    resetn = 1'b1;
    evt_ready = 1'b1;
    r = cyc;
    step(5);
    total++; if (btn_state !== 4'b0000) begin bad++; $display("FAIL post_reset_state_c5: got %b want 0000", btn_state); end
    step(1);
    total++; if (btn_state !== 4'b0001) begin bad++; $display("FAIL post_reset_state_c6: got %b want 0001", btn_state); end
    step(6);
    total++; if (q_t.size() != 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", q_t.size()); end
    total++;
    if (q_t.size() < 1) begin
      bad++; $display("FAIL post_reset_press: missing, want t=8 id=0 ty=0");
    end else if (q_t[0] - r != 8 || q_id[0] != 0 || q_ty[0] != 0) begin
      bad++; $display("FAIL post_reset_press: got t=%0d id=%0d ty=%0d want t=8 id=0 ty=0", q_t[0] - r, q_id[0], q_ty[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    step(5);
    test_glitch();
    step(5);
    test_long_press();
    step(5);
    test_back_to_back();
    step(5);
    test_overflow();
    step(5);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
